// File: rtl/aes_pkg.sv
// Shared constants and the loader state encoding for the unrolled AES datapath.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES_WORD_W      = 32;
    localparam int AES_BLOCK_WORDS = AES_BLOCK_W / AES_WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_KEY,
        ST_FILL_DATA,
        ST_HOLD
    } loader_state_e;

endpackage

// File: rtl/aes_word_shifter.sv
// Big-endian word assembler: the first word lands in the low slot and is pushed
// upward by each following word, so after WIDTH/32 words it sits in the MSBs.
module aes_word_shifter
    import aes_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_first,
    input  logic                  shift_in,
    input  logic                  clear,
    input  logic [AES_WORD_W-1:0] word,
    output logic [WIDTH-1:0]      value
);

    // NOTE: the register is reset even though it is datapath, because blk_in
    // must read as zero out of reset and after an asynchronous reset mid-load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load_first) begin
            value <= WIDTH'(word);
        end else if (shift_in) begin
            value <= {value[WIDTH-AES_WORD_W-1:0], word};
        end
    end

endmodule

// File: rtl/aes_word_loader.sv
// Word-stream front end of the AES encryptor: assembles a cipher key and a
// 128-bit plaintext block and offers both through a single-entry handshake.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int NK = N / AES_WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AES_WORD_W-1:0]  s_data,
    input  logic                   s_valid,
    input  logic                   s_is_key,
    output logic                   s_ready,
    output logic [AES_BLOCK_W-1:0] blk_in,
    output logic [N-1:0]           blk_key,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   key_loaded,
    output logic                   err
);

    localparam int CW = $clog2(NK + 1);
    typedef logic [CW-1:0] count_t;

    loader_state_e state;
    count_t        count;

    logic          accept;
    logic          key_word;
    logic          data_word;
    logic          key_first;
    logic          key_shift;
    logic          key_clear;
    logic          dat_first;
    logic          dat_shift;
    logic          dat_clear;
    logic          key_done;
    logic          data_done;
    logic [N-1:0]  key_shadow;
    logic [N-1:0]  key_commit;

    // Decoded from registered state only, so there is no path from s_valid.
    assign s_ready   = (state != ST_HOLD);
    assign accept    = s_valid && s_ready;
    assign key_word  = accept && s_is_key;
    assign data_word = accept && !s_is_key;

    assign key_commit = {key_shadow[N-AES_WORD_W-1:0], s_data};
    assign key_done   = key_shift && (count == count_t'(NK - 1));
    assign data_done  = dat_shift && (count == count_t'(AES_BLOCK_WORDS - 1));

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        key_first = 1'b0;
        key_shift = 1'b0;
        key_clear = 1'b0;
        dat_first = 1'b0;
        dat_shift = 1'b0;
        dat_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                key_first = key_word;
                dat_first = data_word && key_loaded;
            end
            ST_FILL_KEY: begin
                key_shift = key_word;
                key_clear = data_word;
                dat_first = data_word && key_loaded;
            end
            ST_FILL_DATA: begin
                dat_shift = data_word;
                dat_clear = key_word;
                key_first = key_word;
            end
            default: begin
            end
        endcase
    end

    aes_word_shifter #(.WIDTH(N)) u_key_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_first (key_first),
        .shift_in   (key_shift),
        .clear      (key_clear),
        .word       (s_data),
        .value      (key_shadow)
    );

    aes_word_shifter #(.WIDTH(AES_BLOCK_W)) u_data_block (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_first (dat_first),
        .shift_in   (dat_shift),
        .clear      (dat_clear),
        .word       (s_data),
        .value      (blk_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            blk_key    <= '0;
            key_loaded <= 1'b0;
            blk_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (key_word) begin
                        state <= ST_FILL_KEY;
                        count <= count_t'(1);
                    end else if (data_word) begin
                        if (key_loaded) begin
                            state <= ST_FILL_DATA;
                            count <= count_t'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_FILL_KEY: begin
                    if (key_done) begin
                        blk_key    <= key_commit;
                        key_loaded <= 1'b1;
                        state      <= ST_IDLE;
                        count      <= '0;
                    end else if (key_word) begin
                        count <= count + count_t'(1);
                    end else if (data_word) begin
                        // Abandon the partial key; the data word is treated as if seen in IDLE.
                        err <= 1'b1;
                        if (key_loaded) begin
                            state <= ST_FILL_DATA;
                            count <= count_t'(1);
                        end else begin
                            state <= ST_IDLE;
                            count <= '0;
                        end
                    end
                end
                ST_FILL_DATA: begin
                    if (data_done) begin
                        state     <= ST_HOLD;
                        blk_valid <= 1'b1;
                        count     <= '0;
                    end else if (data_word) begin
                        count <= count + count_t'(1);
                    end else if (key_word) begin
                        err   <= 1'b1;
                        state <= ST_FILL_KEY;
                        count <= count_t'(1);
                    end
                end
                ST_HOLD: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Scoreboard bench for aes_word_loader: a word-level model predicts blocks,
// keys and error pulses; a separate monitor compares every cycle.
module tb_aes_word_loader;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_is_key;
    logic         s_ready;
    logic [127:0] blk_in;
    logic [127:0] blk_key;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic         key_loaded;
    logic         err;

    logic [31:0]  b_s_data;
    logic         b_s_valid;
    logic         b_s_is_key;
    logic         b_s_ready;
    logic [127:0] b_blk_in;
    logic [255:0] b_blk_key;
    logic         b_blk_valid;
    logic         b_blk_ready;
    logic         b_key_loaded;
    logic         b_err;

    aes_word_loader #(.N(128), .NK(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_is_key(s_is_key),
        .s_ready(s_ready), .blk_in(blk_in), .blk_key(blk_key), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .key_loaded(key_loaded), .err(err)
    );

    aes_word_loader #(.N(256), .NK(8)) dut256 (
        .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_is_key(b_s_is_key),
        .s_ready(b_s_ready), .blk_in(b_blk_in), .blk_key(b_blk_key), .blk_valid(b_blk_valid),
        .blk_ready(b_blk_ready), .key_loaded(b_key_loaded), .err(b_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer side: fixed value or random, always applied 1 time unit after the edge.
    bit   ready_mode = 1'b0;
    logic ready_val  = 1'b1;
    always @(posedge clk) begin
        #1;
        blk_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Reference model: words in arrival order, packed with plain arithmetic.
    logic [31:0]  key_part[$];
    logic [31:0]  dat_part[$];
    logic [127:0] exp_q[$];
    logic [127:0] m_key;
    logic         m_loaded;
    logic         exp_err;

    function automatic logic [255:0] pack(input logic [31:0] q[$]);
        logic [255:0] v;
        v = '0;
        foreach (q[i]) v = (v << 32) | 256'(q[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            key_part.delete();
            dat_part.delete();
            exp_q.delete();
            m_key    = '0;
            m_loaded = 1'b0;
            exp_err  = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (s_valid && s_ready) begin
                if (s_is_key) begin
                    if (dat_part.size() != 0) begin
                        exp_err = 1'b1;
                        dat_part.delete();
                    end
                    key_part.push_back(s_data);
                    if (key_part.size() == 4) begin
                        m_key    = 128'(pack(key_part));
                        m_loaded = 1'b1;
                        key_part.delete();
                    end
                end else begin
                    if (key_part.size() != 0) begin
                        exp_err = 1'b1;
                        key_part.delete();
                    end
                    if (!m_loaded) begin
                        exp_err = 1'b1;
                    end else begin
                        dat_part.push_back(s_data);
                        if (dat_part.size() == 4) begin
                            exp_q.push_back(128'(pack(dat_part)));
                            dat_part.delete();
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model 2 time units after each edge.
    logic prev_valid = 1'b0;
    int   rise_cyc[$];
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("err", err, exp_err);
            check("key_loaded", key_loaded, m_loaded);
            check("blk_key", blk_key, m_key);
            check("blk_valid", blk_valid, exp_q.size() != 0);
            check("s_ready", s_ready, exp_q.size() == 0);
            if (blk_valid && exp_q.size() != 0) begin
                check("blk_in", blk_in, exp_q[0]);
                if (blk_ready) void'(exp_q.pop_front());
            end
            if (blk_valid && !prev_valid) rise_cyc.push_back(cyc);
            prev_valid = blk_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send(input logic [31:0] w, input logic k);
        bit done;
        done     = 1'b0;
        s_data   = w;
        s_is_key = k;
        s_valid  = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: word %0h not accepted within 64 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ready(input logic mode, input logic v);
        @(negedge clk);
        ready_mode = mode;
        ready_val  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b1);
        check({tag, "_blk_valid"}, blk_valid, 1'b0);
        check({tag, "_blk_in"}, blk_in, '0);
        check({tag, "_blk_key"}, blk_key, '0);
        check({tag, "_key_loaded"}, key_loaded, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        reset_checks(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_fips_key();
        send(32'h00010203, 1'b1);
        send(32'h04050607, 1'b1);
        send(32'h08090a0b, 1'b1);
        send(32'h0c0d0e0f, 1'b1);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        s_valid     = 1'b0;
        s_is_key    = 1'b0;
        s_data      = '0;
        b_s_valid   = 1'b0;
        b_s_is_key  = 1'b0;
        b_s_data    = '0;
        b_blk_ready = 1'b1;
        rst_n       = 1'b0;
        #1;
        reset_checks("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 256-bit key: nothing visible until the 8th word is accepted.
        for (int i = 0; i < 8; i++) begin
            b_s_data   = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            b_s_is_key = 1'b1;
            b_s_valid  = 1'b1;
            check("k256_s_ready", b_s_ready, 1'b1);
            @(posedge clk);
            #1;
            check("k256_blk_key", b_blk_key, (i < 7) ? 256'd0 : KEY_256);
            check("k256_key_loaded", b_key_loaded, i == 7);
        end
        b_s_valid = 1'b0;
        check("k256_err", b_err, 1'b0);

        // Data before any key: dropped with an error pulse.
        send(32'hdeadbeef, 1'b0);
        idle(3);

        // FIPS-197 key and plaintext, consumer always ready.
        send_fips_key();
        send(32'h00112233, 1'b0);
        send(32'h44556677, 1'b0);
        send(32'h8899aabb, 1'b0);
        send(32'hccddeeff, 1'b0);
        idle(0);
        @(negedge clk);
        check("fips_blk_valid", blk_valid, 1'b1);
        check("fips_blk_in", blk_in, FIPS_PT);
        check("fips_blk_key", blk_key, FIPS_KEY);
        check("fips_key_loaded", key_loaded, 1'b1);
        idle(3);

        // Back-pressure for 3 cycles, then back-to-back blocks under the same key.
        set_ready(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(32'ha0a0a0a0 + 32'(i), 1'b0);
        idle(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_s_ready", s_ready, 1'b0);
            check("hold_blk_valid", blk_valid, 1'b1);
            check("hold_blk_in", blk_in, 128'ha0a0a0a0a0a0a0a1a0a0a0a2a0a0a0a3);
        end
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send($urandom, 1'b0);
        idle(4);
        check("rise_count", rise_cyc.size() >= 2, 1'b1);
        if (rise_cyc.size() >= 2)
            check("block_spacing", rise_cyc[rise_cyc.size() - 1] - rise_cyc[rise_cyc.size() - 2], 5);

        // Two key words then data: abort keeps the FIPS key, data starts a block.
        send(32'h11111111, 1'b1);
        send(32'h22222222, 1'b1);
        send(32'h33333333, 1'b0);
        idle(0);
        @(negedge clk);
        check("abort_key_retained", blk_key, FIPS_KEY);
        check("abort_key_err", err, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(32'h44444444 + 32'(i), 1'b0);
        idle(3);

        // Two data words then a key word: partial block dropped, new key loads.
        send(32'h55555555, 1'b0);
        send(32'h66666666, 1'b0);
        send(32'hcafef00d, 1'b1);
        send(32'h01234567, 1'b1);
        send(32'h89abcdef, 1'b1);
        send(32'h0badc0de, 1'b1);
        idle(0);
        @(negedge clk);
        check("new_key", blk_key, 128'hcafef00d0123456789abcdef0badc0de);
        @(posedge clk);
        #1;
        idle(2);

        // Asynchronous reset during FILL_DATA and during HOLD.
        send(32'h77777777, 1'b0);
        send(32'h88888888, 1'b0);
        idle(0);
        do_reset("rst_fill");
        idle(2);
        send_fips_key();
        set_ready(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(32'h99999999 - 32'(i), 1'b0);
        idle(1);
        check("pre_rst_hold", blk_valid, 1'b1);
        do_reset("rst_hold");
        set_ready(1'b0, 1'b1);
        idle(2);

        // Randomized traffic with a randomly stalling consumer.
        send_fips_key();
        set_ready(1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            send(w, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                idle($urandom_range(1, 2));
            end
        end
        idle(0);
        set_ready(1'b0, 1'b1);
        idle(10);
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
